// File: rtl/inst_fetch.sv
// Instruction fetch stage.
// Owns the program counter and reads one instruction word at a time from
// instruction memory over a req/ack handshake. The fetched word is handed to
// the IF/ID register together with its PC and a fault flag. Branches from ID
// are applied at the next PC advance. The word already being fetched or held
// is the delay slot. A flush from ctrl redirects fetch at once. If a memory
// read is still outstanding, it is drained first.
// All outputs are registered. Each one is computed from the next-state values,
// so in every cycle it matches the state the FSM is in.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_pc_invalid,
    output logic        stallreq_if
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_VALID = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t      state_r,      state_s;
    logic [31:0] pc_r,         pc_s;
    logic [31:0] inst_buf_r,   inst_buf_s;
    logic        fault_r,      fault_s;
    logic        br_pending_r, br_pending_s;
    logic [31:0] br_target_r,  br_target_s;

    logic        imem_req_r,      out_req_s;
    logic [31:0] imem_addr_r,     out_addr_s;
    logic [31:0] if_pc_r,         out_pc_s;
    logic [31:0] if_inst_r,       out_inst_s;
    logic        if_pc_invalid_r, out_invalid_s;
    logic        stallreq_if_r,   out_stallreq_s;

    logic        advance_s;
    logic        req_live_s;
    logic        misaligned_s;

    // Only stall[0] (hold PC) affects this stage; the other bits are shared-vector spares.
    logic        unused_stall_s;
    assign unused_stall_s = ^stall[5:1];

    assign misaligned_s = (pc_r[1:0] != 2'b00);
    assign advance_s    = (state_r == ST_VALID) && !stall[0];
    // A request is on the bus in REQ with an aligned PC, and always in DRAIN.
    assign req_live_s   = ((state_r == ST_REQ) && !misaligned_s) || (state_r == ST_DRAIN);

    // State, datapath and output registers; reset drops imem_req asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            pc_r            <= RESET_PC;
            inst_buf_r      <= 32'h0000_0000;
            fault_r         <= 1'b0;
            br_pending_r    <= 1'b0;
            br_target_r     <= 32'h0000_0000;
            imem_req_r      <= 1'b0;
            imem_addr_r     <= RESET_PC;
            if_pc_r         <= RESET_PC;
            if_inst_r       <= 32'h0000_0000;
            if_pc_invalid_r <= 1'b0;
            stallreq_if_r   <= 1'b1;
        end else begin
            state_r         <= state_s;
            pc_r            <= pc_s;
            inst_buf_r      <= inst_buf_s;
            fault_r         <= fault_s;
            br_pending_r    <= br_pending_s;
            br_target_r     <= br_target_s;
            imem_req_r      <= out_req_s;
            imem_addr_r     <= out_addr_s;
            if_pc_r         <= out_pc_s;
            if_inst_r       <= out_inst_s;
            if_pc_invalid_r <= out_invalid_s;
            stallreq_if_r   <= out_stallreq_s;
        end
    end

    // Next-state logic: flush overrides everything; branches are latched unless applied by an advance.
    always_comb begin
        state_s      = state_r;
        pc_s         = pc_r;
        inst_buf_s   = inst_buf_r;
        fault_s      = fault_r;
        br_pending_s = br_pending_r;
        br_target_s  = br_target_r;

        if (flush) begin
            pc_s         = new_pc;
            br_pending_s = 1'b0;
            fault_s      = 1'b0;
            case (state_r)
                ST_IDLE:  state_s = ST_REQ;
                ST_VALID: state_s = ST_REQ;
                ST_REQ: begin
                    if (req_live_s && !imem_ack) begin
                        state_s = ST_DRAIN;
                    end else begin
                        state_s = ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    if (imem_ack) begin
                        state_s = ST_REQ;
                    end else begin
                        state_s = ST_DRAIN;
                    end
                end
                default:  state_s = ST_IDLE;
            endcase
        end else begin
            if (branch_flag && !advance_s) begin
                br_target_s  = branch_target;
                br_pending_s = 1'b1;
            end else begin
                br_target_s  = br_target_r;
            end

            case (state_r)
                ST_IDLE: begin
                    state_s = ST_REQ;
                end
                ST_REQ: begin
                    if (misaligned_s) begin
                        inst_buf_s = 32'h0000_0000;
                        fault_s    = 1'b1;
                        state_s    = ST_VALID;
                    end else if (imem_ack) begin
                        inst_buf_s = imem_rdata;
                        fault_s    = imem_err;
                        state_s    = ST_VALID;
                    end else begin
                        state_s    = ST_REQ;
                    end
                end
                ST_VALID: begin
                    if (!stall[0]) begin
                        state_s = ST_REQ;
                        if (branch_flag) begin
                            pc_s = branch_target;
                        end else if (br_pending_r) begin
                            pc_s         = br_target_r;
                            br_pending_s = 1'b0;
                        end else begin
                            pc_s = pc_r + 32'd4;
                        end
                    end else begin
                        state_s = ST_VALID;
                    end
                end
                ST_DRAIN: begin
                    if (imem_ack) begin
                        state_s = ST_REQ;
                    end else begin
                        state_s = ST_DRAIN;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // Output decode from next-state values; DRAIN keeps the abandoned request's address on the bus.
    always_comb begin
        out_req_s      = ((state_s == ST_REQ) && (pc_s[1:0] == 2'b00)) || (state_s == ST_DRAIN);
        out_pc_s       = pc_s;
        if (state_s == ST_DRAIN) begin
            out_addr_s = imem_addr_r;
        end else begin
            out_addr_s = pc_s;
        end
        if (state_s == ST_VALID) begin
            out_inst_s     = inst_buf_s;
            out_invalid_s  = fault_s;
            out_stallreq_s = 1'b0;
        end else begin
            out_inst_s     = 32'h0000_0000;
            out_invalid_s  = 1'b0;
            out_stallreq_s = 1'b1;
        end
    end

    assign imem_req      = imem_req_r;
    assign imem_addr     = imem_addr_r;
    assign if_pc         = if_pc_r;
    assign if_inst       = if_inst_r;
    assign if_pc_invalid = if_pc_invalid_r;
    assign stallreq_if   = stallreq_if_r;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed testbench for inst_fetch.
// The memory model acks after wait_n cycles of a held request.
// It returns 0x2401_0005 at address 0 and (addr | 0xC000_0000) everywhere else.
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        imem_err;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_pc_invalid;
    logic        stallreq_if;

    int          errors;
    int          checks;
    int          wait_n;
    int          wcnt;
    logic        err_mode;

    inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .new_pc        (new_pc),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .imem_err      (imem_err),
        .if_pc         (if_pc),
        .if_inst       (if_inst),
        .if_pc_invalid (if_pc_invalid),
        .stallreq_if   (stallreq_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0000) return 32'h2401_0005;
        else return a | 32'hC000_0000;
    endfunction

    assign imem_ack   = imem_req && (wcnt == wait_n);
    assign imem_rdata = mem_word(imem_addr);
    assign imem_err   = imem_ack && err_mode;

    // Wait-state counter of the memory model.
    always @(posedge clk or posedge rst) begin
        if (rst) wcnt <= 0;
        else if (imem_req && !imem_ack) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int wn);
        rst = 1'b1; stall = 6'd0; flush = 1'b0; new_pc = 32'd0;
        branch_flag = 1'b0; branch_target = 32'd0; err_mode = 1'b0; wait_n = wn;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (stallreq_if === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 6'd0; flush = 1'b0; new_pc = 32'd0;
        branch_flag = 1'b0; branch_target = 32'd0; err_mode = 1'b0; wait_n = 0;
        #3;
        checks++;
        if ({imem_req, imem_addr, if_pc, if_inst, if_pc_invalid, stallreq_if} !==
            {1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: got req=%b addr=%h pc=%h inst=%h inv=%b stq=%b, expected 0 0 0 0 0 1",
                     imem_req, imem_addr, if_pc, if_inst, if_pc_invalid, stallreq_if);
        end
    endtask

    task automatic test_zero_wait();
        do_reset(0);
        checks++;
        if ({imem_req, stallreq_if} !== 2'b01) begin
            errors++; $display("FAIL zw_idle: got req=%b stq=%b, expected 0 1", imem_req, stallreq_if);
        end
        tick();
        checks++;
        if ({imem_req, imem_addr, stallreq_if} !== {1'b1, 32'h0, 1'b1}) begin
            errors++; $display("FAIL zw_req0: got req=%b addr=%h stq=%b, expected 1 0 1", imem_req, imem_addr, stallreq_if);
        end
        tick();
        checks++;
        if ({imem_req, stallreq_if, if_pc, if_inst, if_pc_invalid} !== {1'b0, 1'b0, 32'h0, 32'h2401_0005, 1'b0}) begin
            errors++; $display("FAIL zw_valid0: got req=%b stq=%b pc=%h inst=%h inv=%b, expected 0 0 0 24010005 0",
                               imem_req, stallreq_if, if_pc, if_inst, if_pc_invalid);
        end
        tick();
        checks++;
        if ({imem_req, imem_addr, if_inst, stallreq_if} !== {1'b1, 32'h4, 32'h0, 1'b1}) begin
            errors++; $display("FAIL zw_req4: got req=%b addr=%h inst=%h stq=%b, expected 1 4 0 1", imem_req, imem_addr, if_inst, stallreq_if);
        end
        tick();
        checks++;
        if ({if_pc, if_inst, stallreq_if} !== {32'h4, 32'hC000_0004, 1'b0}) begin
            errors++; $display("FAIL zw_valid4: got pc=%h inst=%h stq=%b, expected 4 c0000004 0", if_pc, if_inst, stallreq_if);
        end
    endtask

    task automatic test_wait_stall();
        do_reset(3);
        for (int c = 1; c <= 4; c++) begin
            tick();
            checks++;
            if ({imem_req, imem_addr, stallreq_if} !== {1'b1, 32'h0, 1'b1}) begin
                errors++; $display("FAIL ws_hold cycle %0d: got req=%b addr=%h stq=%b, expected 1 0 1", c, imem_req, imem_addr, stallreq_if);
            end
        end
        tick();
        stall = 6'b000001;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) stall = 6'd0;
            checks++;
            if ({imem_req, stallreq_if, if_pc, if_inst} !== {1'b0, 1'b0, 32'h0, 32'h2401_0005}) begin
                errors++; $display("FAIL ws_stall step %0d: got req=%b stq=%b pc=%h inst=%h, expected 0 0 0 24010005",
                                   c, imem_req, stallreq_if, if_pc, if_inst);
            end
            tick();
        end
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h4}) begin
            errors++; $display("FAIL ws_release: got req=%b addr=%h, expected 1 4", imem_req, imem_addr);
        end
    endtask

    task automatic test_branch();
        bit ok;
        do_reset(1);
        wait_valid(ok);
        tick();
        wait_valid(ok);
        tick();
        checks++;
        if ({ok, imem_req, imem_addr} !== {1'b1, 1'b1, 32'h8}) begin
            errors++; $display("FAIL br_fetch8: got ok=%b req=%b addr=%h, expected 1 1 8", ok, imem_req, imem_addr);
        end
        branch_flag = 1'b1; branch_target = 32'h100;
        tick();
        branch_flag = 1'b0; branch_target = 32'h0;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h8}) begin
            errors++; $display("FAIL br_slot_req: got req=%b addr=%h, expected 1 8", imem_req, imem_addr);
        end
        tick();
        checks++;
        if ({stallreq_if, if_pc, if_inst} !== {1'b0, 32'h8, 32'hC000_0008}) begin
            errors++; $display("FAIL br_slot_valid: got stq=%b pc=%h inst=%h, expected 0 8 c0000008", stallreq_if, if_pc, if_inst);
        end
        tick();
        checks++;
        if ({imem_req, imem_addr, if_pc} !== {1'b1, 32'h100, 32'h100}) begin
            errors++; $display("FAIL br_target: got req=%b addr=%h pc=%h, expected 1 100 100", imem_req, imem_addr, if_pc);
        end
        wait_valid(ok);
        branch_flag = 1'b1; branch_target = 32'h200;
        tick();
        branch_flag = 1'b0;
        checks++;
        if ({ok, imem_req, imem_addr} !== {1'b1, 1'b1, 32'h200}) begin
            errors++; $display("FAIL br_advance: got ok=%b req=%b addr=%h, expected 1 1 200", ok, imem_req, imem_addr);
        end
        wait_valid(ok);
        tick();
        checks++;
        if ({ok, imem_req, imem_addr} !== {1'b1, 1'b1, 32'h204}) begin
            errors++; $display("FAIL br_no_pending: got ok=%b req=%b addr=%h, expected 1 1 204", ok, imem_req, imem_addr);
        end
    endtask

    task automatic test_flush();
        do_reset(2);
        flush = 1'b1; new_pc = 32'h20;
        tick();
        flush = 1'b0;
        branch_flag = 1'b1; branch_target = 32'h300;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h20}) begin
            errors++; $display("FAIL fl_req20: got req=%b addr=%h, expected 1 20", imem_req, imem_addr);
        end
        tick();
        branch_flag = 1'b0;
        flush = 1'b1; new_pc = 32'h180;
        tick();
        flush = 1'b0;
        checks++;
        if ({imem_req, imem_addr, if_pc, stallreq_if} !== {1'b1, 32'h20, 32'h180, 1'b1}) begin
            errors++; $display("FAIL fl_drain: got req=%b addr=%h pc=%h stq=%b, expected 1 20 180 1", imem_req, imem_addr, if_pc, stallreq_if);
        end
        tick();
        checks++;
        if ({imem_req, imem_addr, stallreq_if} !== {1'b1, 32'h180, 1'b1}) begin
            errors++; $display("FAIL fl_newreq: got req=%b addr=%h stq=%b, expected 1 180 1", imem_req, imem_addr, stallreq_if);
        end
        repeat (3) tick();
        checks++;
        if ({stallreq_if, if_pc, if_inst} !== {1'b0, 32'h180, 32'hC000_0180}) begin
            errors++; $display("FAIL fl_valid: got stq=%b pc=%h inst=%h, expected 0 180 c0000180", stallreq_if, if_pc, if_inst);
        end
        tick();
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h184}) begin
            errors++; $display("FAIL fl_pending_cleared: got req=%b addr=%h, expected 1 184", imem_req, imem_addr);
        end
    endtask

    task automatic test_err_misaligned();
        do_reset(0);
        err_mode = 1'b1;
        repeat (2) tick();
        err_mode = 1'b0;
        checks++;
        if ({stallreq_if, if_pc_invalid, if_inst} !== {1'b0, 1'b1, 32'h2401_0005}) begin
            errors++; $display("FAIL err_valid: got stq=%b inv=%b inst=%h, expected 0 1 24010005", stallreq_if, if_pc_invalid, if_inst);
        end
        branch_flag = 1'b1; branch_target = 32'h102;
        tick();
        branch_flag = 1'b0;
        checks++;
        if ({imem_req, if_pc, stallreq_if, if_pc_invalid} !== {1'b0, 32'h102, 1'b1, 1'b0}) begin
            errors++; $display("FAIL mis_req: got req=%b pc=%h stq=%b inv=%b, expected 0 102 1 0", imem_req, if_pc, stallreq_if, if_pc_invalid);
        end
        stall = 6'b000001;
        tick();
        checks++;
        if ({imem_req, if_pc, if_inst, if_pc_invalid, stallreq_if} !== {1'b0, 32'h102, 32'h0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL mis_valid: got req=%b pc=%h inst=%h inv=%b stq=%b, expected 0 102 0 1 0",
                               imem_req, if_pc, if_inst, if_pc_invalid, stallreq_if);
        end
        stall = 6'd0;
    endtask

    task automatic test_reset_mid();
        do_reset(0);
        repeat (2) tick();
        wait_n = 3;
        tick();
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h4}) begin
            errors++; $display("FAIL rm_req4: got req=%b addr=%h, expected 1 4", imem_req, imem_addr);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({imem_req, imem_addr, if_pc, stallreq_if} !== {1'b0, 32'h0, 32'h0, 1'b1}) begin
            errors++; $display("FAIL rm_async: got req=%b addr=%h pc=%h stq=%b, expected 0 0 0 1", imem_req, imem_addr, if_pc, stallreq_if);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++; $display("FAIL rm_idle: got req=%b, expected 0", imem_req);
        end
        tick();
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
            errors++; $display("FAIL rm_resume: got req=%b addr=%h, expected 1 0", imem_req, imem_addr);
        end
    endtask

    task automatic test_pc_wrap();
        do_reset(0);
        flush = 1'b1; new_pc = 32'hFFFF_FFFC;
        tick();
        flush = 1'b0;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
            errors++; $display("FAIL wrap_req: got req=%b addr=%h, expected 1 fffffffc", imem_req, imem_addr);
        end
        tick();
        checks++;
        if ({if_pc, if_inst} !== {32'hFFFF_FFFC, 32'hFFFF_FFFC}) begin
            errors++; $display("FAIL wrap_valid: got pc=%h inst=%h, expected fffffffc fffffffc", if_pc, if_inst);
        end
        tick();
        checks++;
        if ({imem_req, imem_addr, if_pc} !== {1'b1, 32'h0, 32'h0}) begin
            errors++; $display("FAIL wrap_next: got req=%b addr=%h pc=%h, expected 1 0 0", imem_req, imem_addr, if_pc);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_zero_wait();
        test_wait_stall();
        test_branch();
        test_flush();
        test_err_misaligned();
        test_reset_mid();
        test_pc_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage: owns the program counter, issues word reads to instruction memory over a req/ack handshake, and presents `if_pc`/`if_inst`/`if_pc_invalid` to the IF/ID pipeline register. It obeys the shared `stall[5:0]`/`flush` control vector and raises `stallreq_if` while no fetched instruction is available. It sits between instruction memory and IF/ID; its inputs come from ID (branch) and ctrl (stall, flush, new_pc).

## Interface
- `RESET_PC`, 32'h0000_0000: PC loaded on reset.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `stall`  in  6  pipeline stall vector; only `stall[0]` (hold PC) is used.
- `flush`  in  1  exception flush; redirects fetch to `new_pc`.
- `new_pc`  in  32  flush target.
- `branch_flag`  in  1  one-cycle pulse from ID: taken branch/jump.
- `branch_target`  in  32  branch destination, valid with `branch_flag`.
- `imem_req`  out  1  read request, held until `imem_ack`.
- `imem_addr`  out  32  read address; equals current PC.
- `imem_ack`  in  1  read complete; may arrive in the same cycle as `imem_req`.
- `imem_rdata`  in  32  instruction word, valid with `imem_ack`.
- `imem_err`  in  1  bus error, valid with `imem_ack`.
- `if_pc`  out  32  PC of the presented instruction.
- `if_inst`  out  32  instruction word; 0 when not valid.
- `if_pc_invalid`  out  1  1 = fetch fault (misaligned PC or bus error).
- `stallreq_if`  out  1  1 = no valid instruction this cycle.

## Operation
- State: `pc`, `inst_buf`, `fault`, `br_pending`, `br_target`, FSM {IDLE, REQ, VALID, DRAIN}.
- Reset: pc=RESET_PC, state=IDLE, inst_buf=0, fault=0, br_pending=0. Outputs: imem_req=0, imem_addr=RESET_PC, if_pc=RESET_PC, if_inst=0, if_pc_invalid=0, stallreq_if=1.
- IDLE: one cycle, no request -> REQ.
- REQ: imem_req=1, imem_addr=pc stable until ack. If pc[1:0]!=0: no request is issued; inst_buf=0, fault=1 -> VALID. On imem_ack: inst_buf=imem_rdata, fault=imem_err -> VALID.
- VALID: if_inst=inst_buf, if_pc_invalid=fault, stallreq_if=0. If stall[0]=1: hold. If stall[0]=0: pc advances -> REQ.
- Next PC on advance, priority: branch_flag this cycle -> branch_target; else br_pending -> br_target (clear pending); else pc+4 (32-bit wrap, 0xFFFF_FFFC+4 = 0).
- branch_flag outside an advance cycle: latch br_target, br_pending=1. The instruction being fetched or held is the delay slot and is never discarded by a branch.
- flush (highest priority, any state): pc=new_pc, br_pending=0, fault=0. From IDLE/VALID -> REQ. From REQ with request outstanding and no ack this cycle -> DRAIN. From REQ with ack this cycle: data discarded -> REQ.
- DRAIN: imem_req=1 at the old address until ack; data/err discarded -> REQ at new pc. A flush during DRAIN updates pc again and stays in DRAIN.
- if_pc always equals pc; if_inst=0 and if_pc_invalid=0 outside VALID; stallreq_if=1 outside VALID.

## Timing
- Zero-wait memory (ack same cycle as req): REQ in cycle N, VALID in N+1, next REQ in N+2; peak throughput one instruction per 2 cycles.
- k wait cycles add k cycles to REQ; stallreq_if stays high throughout.
- Flush to first new request: 1 cycle from IDLE/VALID, or ack-of-old-request + 1 from DRAIN.
- Reset mid-request: imem_req drops asynchronously; memory must tolerate an abandoned request.
- Simultaneous flush and branch_flag: flush wins, branch discarded.
- Simultaneous stall[0]=1 and branch_flag in VALID: branch latched into br_pending, applied on release.

## Test plan
- Reset release, zero-wait memory returning 0x2401_0005 at 0: stallreq_if=1 for cycles 0-1, VALID cycle 2 with if_pc=0, if_inst=0x2401_0005; next request at 0x4 in cycle 3.
- 3-wait-state memory: imem_req held 4 cycles at constant address, stallreq_if=1 throughout; stall[0]=1 for 2 cycles in VALID keeps if_inst unchanged and no new request.
- branch_flag pulse (target 0x100) while fetching 0x8: 0x8 completes (delay slot), next address 0x100; pulse coinciding with advance also yields 0x100.
- flush with new_pc=0x180 during 2-wait fetch at 0x20: old request held to ack, data discarded, next request 0x180, br_pending cleared.
- imem_err on ack: VALID with if_pc_invalid=1; branch to 0x102: no imem_req, if_pc=0x102, if_pc_invalid=1, if_inst=0.
- rst asserted mid-REQ: imem_req=0 immediately, if_pc=RESET_PC; fetch resumes at RESET_PC after IDLE.
